// File: rtl/hweval_pkg.sv
// rtl/hweval_pkg.sv - shared types and constants for the Montgomery evaluation sequencer
package hweval_pkg;

  localparam int CYCLE_W       = 32;
  localparam int DEFAULT_WIDTH = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Odd modulus (Montgomery requires gcd(M, 2) == 1) and fixed evaluation seeds.
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_MODULUS = {1'b1, {1019{1'b0}}, 4'b1011};
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_SEED_A  = {32{32'h0123_4567}};
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_SEED_B  = {32{32'h89AB_CDEF}};

endpackage

// File: rtl/hweval_montgomery_seq_if.sv
// rtl/hweval_montgomery_seq_if.sv - handshake between the sequencer and the multiplier core
interface hweval_montgomery_seq_if #(
  parameter int WIDTH = 1024
) ();

  logic             core_start;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_m;
  logic [WIDTH-1:0] core_result;
  logic             core_done;

  modport master (
    output core_start,
    output core_a,
    output core_b,
    output core_m,
    input  core_result,
    input  core_done
  );

  modport slave (
    input  core_start,
    input  core_a,
    input  core_b,
    input  core_m,
    output core_result,
    output core_done
  );

endinterface

// File: rtl/hweval_sig_fold.sv
// rtl/hweval_sig_fold.sv - signature update: rotl1(sig) ^ XOR-fold of WIDTH/SIG_W result slices
module hweval_sig_fold #(
  parameter int WIDTH = 1024,
  parameter int SIG_W = 32
) (
  input  logic [SIG_W-1:0] sig_in,
  input  logic [WIDTH-1:0] data,
  output logic [SIG_W-1:0] sig_out
);

  logic [SIG_W-1:0] fold;

  always_comb begin
    fold = '0;
    for (int i = 0; i < WIDTH / SIG_W; i++) begin
      fold = fold ^ data[i*SIG_W +: SIG_W];
    end
  end

  assign sig_out = {sig_in[SIG_W-2:0], sig_in[SIG_W-1]} ^ fold;

endmodule

// File: rtl/hweval_montgomery_seq.sv
// rtl/hweval_montgomery_seq.sv - evaluation sequencer driving N_ITER Montgomery multiplications
module hweval_montgomery_seq
  import hweval_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SIG_W   = 32,
  parameter int N_ITER  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 run,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     seed_a,
  input  logic [WIDTH-1:0]     seed_b,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [SIG_W-1:0]     expect_sig,
  hweval_montgomery_seq_if.master core_if,
  output logic                 busy,
  output logic                 finished,
  output logic                 timeout_err,
  output logic [SIG_W-1:0]     signature,
  output logic [CYCLE_W-1:0]   cycles,
  output logic                 data_ok
);

  localparam int ITER_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [SIG_W-1:0]    sig_q, sig_d;
  logic [SIG_W-1:0]    sig_next;
  logic [CYCLE_W-1:0]  cycles_q, cycles_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                tmo_q, tmo_d;
  logic                in_run;

  hweval_sig_fold #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W)
  ) u_sig_fold (
    .sig_in  (sig_q),
    .data    (result_q),
    .sig_out (sig_next)
  );

  assign in_run = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) || (state_q == ST_UPDATE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      sig_q    <= '0;
      cycles_q <= '0;
      iter_q   <= '0;
      wd_q     <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      result_q <= result_d;
      sig_q    <= sig_d;
      cycles_q <= cycles_d;
      iter_q   <= iter_d;
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    result_d = result_q;
    sig_d    = sig_q;
    cycles_d = cycles_q;
    iter_d   = iter_q;
    wd_d     = wd_q;
    tmo_d    = tmo_q;

    if (in_run && (cycles_q != {CYCLE_W{1'b1}})) begin
      cycles_d = cycles_q + CYCLE_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (run) begin
          mode_d   = mode;
          a_d      = seed_a;
          b_d      = seed_b;
          m_d      = modulus;
          sig_d    = '0;
          cycles_d = '0;
          iter_d   = '0;
          tmo_d    = 1'b0;
          state_d  = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end

      // A done strobe arriving on the expiry cycle still counts as success.
      ST_WAIT: begin
        if (core_if.core_done) begin
          result_d = core_if.core_result;
          state_d  = ST_UPDATE;
        end else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      ST_UPDATE: begin
        sig_d = sig_next;
        if (mode_q) begin
          a_d = b_q ^ result_q;
          b_d = result_q;
        end
        if (iter_q == ITER_LAST) begin
          state_d = ST_FINISH;
        end else begin
          iter_d  = iter_q + ITER_W'(1);
          state_d = ST_LAUNCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign core_if.core_start = (state_q == ST_LAUNCH);
  assign core_if.core_a     = a_q;
  assign core_if.core_b     = b_q;
  assign core_if.core_m     = m_q;

  assign busy        = in_run;
  assign finished    = (state_q == ST_FINISH);
  assign timeout_err = tmo_q;
  assign signature   = sig_q;
  assign cycles      = cycles_q;
  assign data_ok     = finished & ~tmo_q & (sig_q == expect_sig);

endmodule

// File: tb/tb_hweval_montgomery_seq.sv
// tb/tb_hweval_montgomery_seq.sv - directed self-checking bench for hweval_montgomery_seq
module tb_hweval_montgomery_seq;
  import hweval_pkg::*;

  localparam int WIDTH   = 16;
  localparam int SIG_W   = 8;
  localparam int N_ITER  = 3;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               resetn, run, mode;
  logic [WIDTH-1:0]   seed_a, seed_b, modulus;
  logic [SIG_W-1:0]   expect_sig;
  logic               busy, finished, timeout_err, data_ok;
  logic [SIG_W-1:0]   signature;
  logic [CYCLE_W-1:0] cycles;

  hweval_montgomery_seq_if #(.WIDTH(WIDTH)) cif ();

  hweval_montgomery_seq #(
    .WIDTH   (WIDTH),
    .SIG_W   (SIG_W),
    .N_ITER  (N_ITER),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .run         (run),
    .mode        (mode),
    .seed_a      (seed_a),
    .seed_b      (seed_b),
    .modulus     (modulus),
    .expect_sig  (expect_sig),
    .core_if     (cif),
    .busy        (busy),
    .finished    (finished),
    .timeout_err (timeout_err),
    .signature   (signature),
    .cycles      (cycles),
    .data_ok     (data_ok)
  );

  // Core model: result = a ^ b, done raised in WAIT cycle done_at after each start.
  logic model_done = 1'b0;
  logic manual_done = 1'b0;
  logic done_en = 1'b1;
  int   done_at = 5;
  int   wcnt = -1;
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] qr[$];

  assign cif.core_done   = model_done | manual_done;
  assign cif.core_result = cif.core_a ^ cif.core_b;

  always @(negedge clk) begin
    if (cif.core_start) begin
      wcnt = 0;
      qa.push_back(cif.core_a);
      qb.push_back(cif.core_b);
    end else if (wcnt >= 0) begin
      wcnt = wcnt + 1;
    end
    model_done = done_en && (wcnt == done_at);
    if (model_done) begin
      qr.push_back(cif.core_a ^ cif.core_b);
      wcnt = -1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    qa.delete();
    qb.delete();
    qr.delete();
  endtask

  task automatic run_wait(output int n);
    clear_logs();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n = 0;
    while (!finished && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int starts;
    resetn = 1'b0; run = 1'b0; mode = 1'b0;
    seed_a = '0; seed_b = '0; modulus = '0; expect_sig = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_sig", signature, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_core_start", cif.core_start, 0);
    chk("rst_core_a", cif.core_a, 0);
    chk("rst_core_m", cif.core_m, 0);

    resetn = 1'b1;
    @(negedge clk);

    // 1: fixed operands
    mode = 1'b0; seed_a = 16'h0001; seed_b = 16'h0002; modulus = 16'h00F1; expect_sig = 8'h09;
    run_wait(n);
    chk("t1_latency", n, 21);
    chk("t1_finished", finished, 1);
    chk("t1_busy", busy, 0);
    chk("t1_cycles", cycles, 21);
    chk("t1_sig", signature, 8'h09);
    chk("t1_timeout", timeout_err, 0);
    chk("t1_data_ok", data_ok, 1);
    chk("t1_core_m", cif.core_m, 16'h00F1);
    chk("t1_nres", qr.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_res", qr[i], 16'h0003);
    expect_sig = 8'h0A;
    #1;
    chk("t6_bad_sig_data_ok", data_ok, 0);
    repeat (5) @(negedge clk);
    chk("t1_hold_cycles", cycles, 21);
    chk("t1_hold_finished", finished, 1);

    // 2: chained operands
    mode = 1'b1; expect_sig = 8'h0B;
    run_wait(n);
    chk("t2_latency", n, 21);
    chk("t2_cycles", cycles, 21);
    chk("t2_sig", signature, 8'h0B);
    chk("t2_data_ok", data_ok, 1);
    chk("t2_nops", qa.size(), 3);
    chk("t2_a0", qa[0], 16'h0001); chk("t2_b0", qb[0], 16'h0002);
    chk("t2_a1", qa[1], 16'h0001); chk("t2_b1", qb[1], 16'h0003);
    chk("t2_a2", qa[2], 16'h0001); chk("t2_b2", qb[2], 16'h0002);
    chk("t2_r0", qr[0], 16'h0003);
    chk("t2_r1", qr[1], 16'h0002);
    chk("t2_r2", qr[2], 16'h0003);

    // 3: core never completes
    done_en = 1'b0; mode = 1'b0; expect_sig = 8'h00;
    run_wait(n);
    chk("t3_latency", n, 9);
    chk("t3_cycles", cycles, 9);
    chk("t3_timeout", timeout_err, 1);
    chk("t3_finished", finished, 1);
    chk("t3_data_ok", data_ok, 0);

    // 6b: done on the expiry cycle wins over the watchdog
    done_en = 1'b1; done_at = TIMEOUT; expect_sig = 8'h09;
    run_wait(n);
    chk("t6_coinc_timeout", timeout_err, 0);
    chk("t6_coinc_cycles", cycles, 30);
    chk("t6_coinc_sig", signature, 8'h09);
    chk("t6_coinc_data_ok", data_ok, 1);
    done_at = 5;

    // 4: reset during the second WAIT
    clear_logs();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    starts = 0; n = 0;
    while (starts < 2 && n < 50) begin
      if (cif.core_start) starts++;
      if (starts < 2) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_second_launch", starts, 2);
    repeat (2) @(negedge clk);
    chk("t4_pre_sig", signature, 8'h03);
    chk("t4_pre_busy", busy, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("t4_core_start", cif.core_start, 0);
    chk("t4_busy", busy, 0);
    chk("t4_sig", signature, 0);
    chk("t4_cycles", cycles, 0);
    chk("t4_finished", finished, 0);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    @(negedge clk);
    chk("t5_idle_done_busy", busy, 0);
    chk("t5_idle_done_finished", finished, 0);
    chk("t5_idle_done_cycles", cycles, 0);
    chk("t5_idle_done_start", cif.core_start, 0);

    // 5: run while busy is ignored, run in FINISH restarts
    mode = 1'b0; expect_sig = 8'h09;
    clear_logs();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_mid", busy, 1);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n = 4;
    while (!finished && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_latency", n, 21);
    chk("t5_cycles", cycles, 21);
    chk("t5_sig", signature, 8'h09);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("t5_restart_finished", finished, 0);
    chk("t5_restart_busy", busy, 1);
    chk("t5_restart_start", cif.core_start, 1);
    chk("t5_restart_cycles", cycles, 0);
    chk("t5_restart_sig", signature, 0);
    n = 0;
    while (!finished && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_rerun_cycles", cycles, 21);
    chk("t5_rerun_data_ok", data_ok, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
